// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: runs NUM_TRACES fixed-key AES encryptions, injects LFSR noise, captures ciphertexts.
// Optional scope trigger built only when AES_TRACE_TRIGGER_EN is defined.
module aes_trace_sequencer #(
   parameter int DATA_W = 128,
   parameter int NUM_TRACES = 16,
   parameter int EN_HOLD = 51,
   parameter int GAP_CYCLES = 15,
   parameter int NOISE_CYCLES = 3,
   parameter logic [127:0] LFSR_SEED = 128'h1,
   localparam int IDX_W = $clog2(NUM_TRACES + 1)
) (
   input  logic              AES_clk,
   input  logic              AES_rst,
   input  logic              start,
   input  logic [DATA_W-1:0] key_in,
   input  logic [DATA_W-1:0] pt_seed,
   output logic              AES_en,
   output logic [DATA_W-1:0] AES_data_in,
   output logic [DATA_W-1:0] AES_key_in,
   input  logic              AES_data_out_valid,
   input  logic [DATA_W-1:0] AES_data_out,
   output logic [DATA_W-1:0] ct_out,
   output logic              ct_valid,
   output logic [IDX_W-1:0]  trace_idx,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic              trigger
);

   localparam int MAX_A = (EN_HOLD > GAP_CYCLES) ? EN_HOLD : GAP_CYCLES;
   localparam int MAX_CNT = (MAX_A > NOISE_CYCLES) ? MAX_A : NOISE_CYCLES;
   localparam int CNT_W = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(EN_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] NOISE_LAST = CNT_W'((NOISE_CYCLES > 0) ? NOISE_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TRACES - 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_NOISE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] pt_q, key_q, ct_q;
   logic [127:0]      lfsr_q;
   logic [IDX_W-1:0]  idx_q;
   logic              got_q, ct_vld_q, tmo_q;
   logic              phase_end, trace_end, accept, capture;

   // Fibonacci LFSR, taps at polynomial positions 128,126,101,99
   function automatic logic [127:0] lfsr_step(input logic [127:0] s);
      return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
   endfunction

   always_comb begin
      state_d = state_q;
      phase_end = 1'b0;
      trace_end = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (cnt_q == RUN_LAST) begin
               phase_end = 1'b1;
               if (GAP_CYCLES > 0) state_d = S_GAP;
               else if (NOISE_CYCLES > 0) state_d = S_NOISE;
               else trace_end = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               phase_end = 1'b1;
               if (NOISE_CYCLES > 0) state_d = S_NOISE;
               else trace_end = 1'b1;
            end
         end
         S_NOISE: begin
            if (cnt_q == NOISE_LAST) begin
               phase_end = 1'b1;
               trace_end = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // whichever phase closes the trace decides between the next trace and the end of the run
      if (trace_end) state_d = (idx_q == IDX_LAST) ? S_DONE : S_RUN;
   end

   assign accept = (state_q == S_IDLE) && start;
   assign capture = (state_q == S_RUN) && AES_data_out_valid && !got_q;

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pt_q     <= '0;
         key_q    <= '0;
         ct_q     <= '0;
         lfsr_q   <= LFSR_SEED;
         idx_q    <= '0;
         got_q    <= 1'b0;
         ct_vld_q <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= (state_q == S_IDLE || phase_end) ? '0 : cnt_q + 1'b1;
         ct_vld_q <= capture;
         if (capture) ct_q <= AES_data_out;
         if (state_q == S_RUN && AES_data_out_valid) got_q <= 1'b1;
         if (state_q == S_RUN && cnt_q == RUN_LAST && !got_q && !AES_data_out_valid)
            tmo_q <= 1'b1;
         if (state_q == S_NOISE) lfsr_q <= lfsr_step(lfsr_q);
         if (accept) begin
            key_q <= key_in;
            pt_q  <= pt_seed;
            idx_q <= '0;
            tmo_q <= 1'b0;
            got_q <= 1'b0;
         end
         // pt_q keeps the plaintext through GAP/NOISE, so the next one is a plain increment
         if (trace_end) begin
            idx_q <= idx_q + 1'b1;
            got_q <= 1'b0;
            pt_q  <= (idx_q == IDX_LAST) ? '0 : pt_q + 1'b1;
         end
      end
   end

   assign AES_en      = (state_q == S_RUN);
   assign busy        = (state_q == S_RUN) || (state_q == S_GAP) || (state_q == S_NOISE);
   assign done        = (state_q == S_DONE);
   assign AES_data_in = (state_q == S_NOISE) ? DATA_W'(lfsr_q) : pt_q;
   assign AES_key_in  = key_q;
   assign ct_out      = ct_q;
   assign ct_valid    = ct_vld_q;
   assign trace_idx   = idx_q;
   assign timeout_err = tmo_q;

`ifdef AES_TRACE_TRIGGER_EN
   logic trig_q;

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) trig_q <= 1'b0;
      else trig_q <= (state_d == S_RUN) && ((state_q != S_RUN) || trace_end);
   end

   assign trigger = trig_q;
`else
   assign trigger = 1'b0;
`endif

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Scoreboard bench for aes_trace_sequencer with a stub AES_top and a behavioural trace model.
module tb_aes_trace_sequencer;
   localparam int NT = 2;
   localparam int EN_HOLD = 51;
   localparam int GAP = 15;
   localparam int NOISE = 3;
   localparam logic [127:0] SEED = 128'h1;
   localparam int IDX_W = $clog2(NT + 1);

   logic AES_clk = 1'b0;
   logic AES_rst = 1'b1;
   logic start = 1'b0;
   logic [127:0] key_in = '0, pt_seed = '0;
   logic AES_en, ct_valid, busy, done, timeout_err, trigger;
   logic [127:0] AES_data_in, AES_key_in, ct_out;
   logic AES_data_out_valid = 1'b0;
   logic [127:0] AES_data_out = '0;
   logic [IDX_W-1:0] trace_idx;

   aes_trace_sequencer #(
      .DATA_W(128), .NUM_TRACES(NT), .EN_HOLD(EN_HOLD), .GAP_CYCLES(GAP),
      .NOISE_CYCLES(NOISE), .LFSR_SEED(SEED)
   ) dut (
      .AES_clk(AES_clk), .AES_rst(AES_rst), .start(start), .key_in(key_in),
      .pt_seed(pt_seed), .AES_en(AES_en), .AES_data_in(AES_data_in),
      .AES_key_in(AES_key_in), .AES_data_out_valid(AES_data_out_valid),
      .AES_data_out(AES_data_out), .ct_out(ct_out), .ct_valid(ct_valid),
      .trace_idx(trace_idx), .busy(busy), .done(done), .timeout_err(timeout_err),
      .trigger(trigger)
   );

   always #5 AES_clk = ~AES_clk;

   typedef struct {
      int           idx;
      logic [127:0] ct;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int total = 0, bad = 0;
   int mode = 0;
   logic [127:0] cur_key = '0, cur_seed = '0, ref_lfsr = SEED;
   bit exp_to = 1'b0, prev_en = 1'b0;
   int win = 0, hold = 0, fall_cnt = 0, trig_cnt = 0, done_cnt = 0;
   int en_cnt = 0, off_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] lfsr_next(input logic [127:0] s);
      logic [127:0] taps;
      taps = '0;
      taps[127] = 1'b1; taps[125] = 1'b1; taps[100] = 1'b1; taps[98] = 1'b1;
      return {s[126:0], ^(s & taps)};
   endfunction

   // stub AES_top: mode 0 valid at RUN cycle 11, 1 never, 2 duplicates plus strays, 3 last RUN cycle
   always @(negedge AES_clk) begin
      if (AES_en) begin en_cnt++; off_cnt = 0; end
      else begin en_cnt = 0; off_cnt++; end
      AES_data_out_valid = 1'b0;
      AES_data_out = rand128();
      case (mode)
         0: if (en_cnt == 11) begin AES_data_out_valid = 1'b1; AES_data_out = AES_data_in ^ AES_key_in; end
         2: begin
            if (en_cnt == 11) begin AES_data_out_valid = 1'b1; AES_data_out = AES_data_in ^ AES_key_in; end
            else if (en_cnt == 20) AES_data_out_valid = 1'b1;
            else if (busy && !AES_en && (off_cnt == 3 || off_cnt == GAP + 2)) AES_data_out_valid = 1'b1;
         end
         3: if (en_cnt == EN_HOLD) begin AES_data_out_valid = 1'b1; AES_data_out = AES_data_in ^ AES_key_in; end
         default: ;
      endcase
   end

   // monitor: pops the scoreboard on ct_valid and checks bus contents against the trace model
   always @(negedge AES_clk) begin
      if (!AES_rst) begin
         if (ct_valid) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL ct_extra: unexpected ct_valid with ct_out %h idx %0d", ct_out, trace_idx);
            end else begin
               e = sb.pop_front();
               check("ct_out", ct_out, e.ct);
               check("ct_idx", 128'(trace_idx), 128'(e.idx));
            end
         end
         if (AES_en && !prev_en) begin win++; hold = 0; fall_cnt = 0; end
         if (AES_en) begin
            hold++;
            check("run_pt", AES_data_in, cur_seed + 128'(win - 1));
            check("run_key", AES_key_in, cur_key);
         end else if (prev_en) begin
            check("en_len", 128'(hold), 128'(EN_HOLD));
            check("timeout", 128'(timeout_err), 128'(exp_to));
         end
         if (!AES_en && busy) begin
            fall_cnt++;
            if (fall_cnt <= GAP) check("gap_hold", AES_data_in, cur_seed + 128'(win - 1));
            else if (fall_cnt <= GAP + NOISE) begin
               check("noise", AES_data_in, ref_lfsr);
               ref_lfsr = lfsr_next(ref_lfsr);
            end
         end
`ifdef AES_TRACE_TRIGGER_EN
         check("trigger", 128'(trigger), 128'(AES_en && !prev_en));
`else
         check("trigger", 128'(trigger), 128'(0));
`endif
         if (trigger) trig_cnt++;
         if (done) begin
            done_cnt++;
            check("done_busy", 128'(busy), 128'(0));
            check("done_data", AES_data_in, 128'(0));
            check("done_to", 128'(timeout_err), 128'(exp_to));
            check("windows", 128'(win), 128'(NT));
            check("sb_empty", 128'(sb.size()), 128'(0));
`ifdef AES_TRACE_TRIGGER_EN
            check("trig_cnt", 128'(trig_cnt), 128'(NT));
`else
            check("trig_cnt", 128'(trig_cnt), 128'(0));
`endif
         end
         prev_en = AES_en;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_en"}, 128'(AES_en), 128'(0));
      check({tag, "_data"}, AES_data_in, 128'(0));
      check({tag, "_key"}, AES_key_in, 128'(0));
      check({tag, "_ct"}, ct_out, 128'(0));
      check({tag, "_ctl"}, 128'({ct_valid, trace_idx, busy, done, timeout_err, trigger}), 128'(0));
   endtask

   task automatic start_run(input logic [127:0] k, input logic [127:0] s, input int m);
      @(negedge AES_clk); #1;
      mode = m; cur_key = k; cur_seed = s; exp_to = (m == 1);
      win = 0; trig_cnt = 0;
      if (m != 1)
         for (int i = 0; i < NT; i++) sb.push_back('{i, (s + 128'(i)) ^ k});
      key_in = k; pt_seed = s; start = 1'b1;
      @(negedge AES_clk); #1;
      start = 1'b0; key_in = rand128(); pt_seed = rand128();
      check("start_busy", 128'(busy), 128'(1));
      check("start_idx", 128'(trace_idx), 128'(0));
      check("start_to", 128'(timeout_err), 128'(0));
   endtask

   task automatic run_one(input logic [127:0] k, input logic [127:0] s, input int m,
                          input bit start_busy, input bit start_done);
      int d0, n;
      d0 = done_cnt;
      start_run(k, s, m);
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         @(negedge AES_clk); #1;
         n++;
         start = start_busy && (n == 30 || n == 100);
      end
      start = 1'b0;
      check("done_seen", 128'(done_cnt), 128'(d0 + 1));
      if (start_done) begin
         start = 1'b1;
         @(negedge AES_clk); #1;
         start = 1'b0;
      end
      repeat (4) begin @(negedge AES_clk); #1; end
      check("idle_after", 128'({busy, AES_en}), 128'(0));
      check("single_done", 128'(done_cnt), 128'(d0 + 1));
      check("key_hold", AES_key_in, k);
   endtask

   initial begin
      int n, d0;
      #12;
      check_all_zero("rst");
      @(negedge AES_clk); #1;
      AES_rst = 1'b0;
      @(negedge AES_clk); #1;
      check_all_zero("idle");

      run_one(128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, 128'h000000a4_00000000_00000000_00000000, 0, 1'b0, 1'b0);
      run_one(rand128(), {128{1'b1}}, 0, 1'b0, 1'b0);
      run_one(rand128(), rand128(), 1, 1'b0, 1'b0);
      run_one(rand128(), rand128(), 2, 1'b1, 1'b0);
      run_one(rand128(), rand128(), 3, 1'b0, 1'b1);

      // reset in the middle of trace 1
      d0 = done_cnt;
      start_run(rand128(), rand128(), 0);
      n = 0;
      while (!(win == 2 && hold == 5) && n < 400) begin @(negedge AES_clk); #1; n++; end
      check("reached_trace1", 128'(win), 128'(2));
      #2 AES_rst = 1'b1;
      #1 check_all_zero("async_rst");
      sb.delete();
      win = 0; hold = 0; fall_cnt = 0; trig_cnt = 0; prev_en = 1'b0; ref_lfsr = SEED;
      repeat (3) @(negedge AES_clk);
      #1 AES_rst = 1'b0;
      check("no_done_rst", 128'(done_cnt), 128'(d0));
      run_one(rand128(), rand128(), 0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++)
         run_one(rand128(), (r == 2) ? ~128'(1) : rand128(), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
